// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the MIPS control units (single-cycle
// cpuCtr and multicycle_ctrl): opcode/func constants, ALUctr codes, the
// multi-cycle state enum, PCSrc/ALUSrcB selector codes and trap causes.
package mips_ctrl_pkg;

   // instruction[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   // instruction[5:0] for R-type
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_op_e;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_TRAP
   } state_e;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_ALUOUT = 2'b01,
      PCSRC_JUMP   = 2'b10
   } pcsrc_e;

   typedef enum logic [1:0] {
      SRCB_RT      = 2'b00,
      SRCB_FOUR    = 2'b01,
      SRCB_IMM     = 2'b10,
      SRCB_IMM_SH2 = 2'b11
   } srcb_e;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'b00,
      CAUSE_ILLEGAL = 2'b01,
      CAUSE_TIMEOUT = 2'b10
   } trap_cause_e;

endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational opcode/func decoder shared by the control units.
//   op, func : instruction[31:26] / instruction[5:0]
//   alu_ctr  : ALU operation code (mips_ctrl_pkg::alu_op_e values)
//   rtype    : op is the R-type opcode
//   legal    : op is supported and, for R-type, func is supported
module alu_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] func,
   output logic [2:0] alu_ctr,
   output logic       rtype,
   output logic       legal
);

   always_comb begin
      alu_ctr = ALU_ADD;
      rtype   = (op == OP_RTYPE);
      legal   = 1'b0;
      case (op)
         OP_RTYPE: begin
            legal = 1'b1;
            case (func)
               FN_ADD:  alu_ctr = ALU_ADD;
               FN_SUB:  alu_ctr = ALU_SUB;
               FN_AND:  alu_ctr = ALU_AND;
               FN_OR:   alu_ctr = ALU_OR;
               FN_SLT:  alu_ctr = ALU_SLT;
               default: legal   = 1'b0;
            endcase
         end
         OP_ORI: begin
            alu_ctr = ALU_OR;
            legal   = 1'b1;
         end
         OP_ADDIU, OP_LW, OP_SW, OP_J: begin
            alu_ctr = ALU_ADD;
            legal   = 1'b1;
         end
         OP_BEQ: begin
            alu_ctr = ALU_SUB;
            legal   = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP)
// for the shared-ALU datapath. Supports add, sub, and, or, slt, ori, addiu,
// lw, sw, beq, j.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   op, func, zero   : IR fields and ALU zero flag
//   mem_ready        : memory access completes this cycle
//   PCWr..ALUctr     : datapath controls (combinational from state/op_q/func_q)
//   rtype            : decoded opcode is R-type
//   instr_done       : one-cycle retire pulse; retired counts them (wraps)
//   trap, trap_cause : sticky fault (01 illegal op/func, 10 memory timeout)
module multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned ALUCTR_W    = 3,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 0
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic [5:0]          op,
   input  logic [5:0]          func,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                PCWr,
   output logic [1:0]          PCSrc,
   output logic                IRWr,
   output logic                MemRd,
   output logic                MemWr,
   output logic                IorD,
   output logic                RegWr,
   output logic                RegDst,
   output logic                MemtoReg,
   output logic                ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic                ExtOp,
   output logic [ALUCTR_W-1:0] ALUctr,
   output logic                rtype,
   output logic                instr_done,
   output logic [CNT_W-1:0]    retired,
   output logic                trap,
   output logic [1:0]          trap_cause
);

   // Counter holds 0..MEM_TIMEOUT-1; the last value is the limit cycle.
   localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LIMIT =
      WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_e            state_q, state_d;
   trap_cause_e       cause_q, cause_d;
   logic [5:0]        op_q, func_q;
   logic [WAIT_W-1:0] wait_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [5:0] dec_op, dec_func;
   logic [2:0] dec_alu;
   logic       dec_rtype, dec_legal;
   logic       timeout_hit;
   logic [2:0] alu_c;

   // In DECODE the IR fields are not yet in op_q/func_q, so decode the live
   // inputs; everywhere else decode the latched copy.
   assign dec_op   = (state_q == ST_DECODE) ? op   : op_q;
   assign dec_func = (state_q == ST_DECODE) ? func : func_q;

   alu_decode u_alu_decode (
      .op      (dec_op),
      .func    (dec_func),
      .alu_ctr (dec_alu),
      .rtype   (dec_rtype),
      .legal   (dec_legal)
   );

   assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LIMIT);

   always_comb begin
      PCWr       = 1'b0;
      PCSrc      = PCSRC_ALU;
      IRWr       = 1'b0;
      MemRd      = 1'b0;
      MemWr      = 1'b0;
      IorD       = 1'b0;
      RegWr      = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_RT;
      ExtOp      = 1'b0;
      alu_c      = 3'b000;
      instr_done = 1'b0;
      state_d    = state_q;
      cause_d    = cause_q;
      if (!sys_rst) begin
         case (state_q)
            ST_FETCH: begin
               MemRd   = 1'b1;
               ALUSrcB = SRCB_FOUR;
               alu_c   = ALU_ADD;
               if (mem_ready) begin
                  IRWr    = 1'b1;
                  PCWr    = 1'b1;
                  state_d = ST_DECODE;
               end else if (timeout_hit) begin
                  state_d = ST_TRAP;
                  cause_d = CAUSE_TIMEOUT;
               end
            end
            ST_DECODE: begin
               ALUSrcB = SRCB_IMM_SH2;
               ExtOp   = 1'b1;
               alu_c   = ALU_ADD;
               if (!dec_legal) begin
                  state_d = ST_TRAP;
                  cause_d = CAUSE_ILLEGAL;
               end else if (dec_op == OP_J) begin
                  PCWr       = 1'b1;
                  PCSrc      = PCSRC_JUMP;
                  instr_done = 1'b1;
                  state_d    = ST_FETCH;
               end else begin
                  state_d = ST_EXEC;
               end
            end
            ST_EXEC: begin
               ALUSrcA = 1'b1;
               alu_c   = dec_alu;
               case (op_q)
                  OP_ORI: begin
                     ALUSrcB = SRCB_IMM;
                     state_d = ST_WB;
                  end
                  OP_ADDIU: begin
                     ALUSrcB = SRCB_IMM;
                     ExtOp   = 1'b1;
                     state_d = ST_WB;
                  end
                  OP_LW, OP_SW: begin
                     ALUSrcB = SRCB_IMM;
                     ExtOp   = 1'b1;
                     state_d = ST_MEM;
                  end
                  OP_BEQ: begin
                     PCWr       = zero;
                     PCSrc      = PCSRC_ALUOUT;
                     instr_done = 1'b1;
                     state_d    = ST_FETCH;
                  end
                  default: state_d = ST_WB;   // R-type (legality checked in DECODE)
               endcase
            end
            ST_MEM: begin
               IorD = 1'b1;
               if (op_q == OP_LW) MemRd = 1'b1;
               else               MemWr = 1'b1;
               if (mem_ready) begin
                  if (op_q == OP_LW) begin
                     state_d = ST_WB;
                  end else begin
                     instr_done = 1'b1;
                     state_d    = ST_FETCH;
                  end
               end else if (timeout_hit) begin
                  state_d = ST_TRAP;
                  cause_d = CAUSE_TIMEOUT;
               end
            end
            ST_WB: begin
               RegWr      = 1'b1;
               RegDst     = dec_rtype;
               MemtoReg   = (op_q == OP_LW);
               instr_done = 1'b1;
               state_d    = ST_FETCH;
            end
            ST_TRAP: ;
            default: state_d = ST_FETCH;
         endcase
      end
   end

   assign ALUctr     = ALUCTR_W'(alu_c);
   assign rtype      = !sys_rst && (state_q != ST_TRAP) && dec_rtype;
   assign trap       = !sys_rst && (state_q == ST_TRAP);
   assign trap_cause = sys_rst ? 2'b00 : cause_q;
   assign retired    = sys_rst ? '0 : cnt_q;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= ST_FETCH;
         cause_q <= CAUSE_NONE;
         op_q    <= '0;
         func_q  <= '0;
         wait_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         if (state_q == ST_DECODE) begin
            op_q   <= op;
            func_q <= func;
         end
         // FETCH/MEM only hold while waiting, so any transition is an entry.
         if (state_d != state_q)
            wait_q <= '0;
         else if (!mem_ready && (state_q == ST_FETCH || state_q == ST_MEM))
            wait_q <= wait_q + 1'b1;
         if (instr_done)
            cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl
// (CNT_W=4 to exercise counter wrap, MEM_TIMEOUT=4).
module tb_multicycle_ctrl;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic [5:0] op, func;
   logic       zero, mem_ready;
   logic       PCWr, IRWr, MemRd, MemWr, IorD, RegWr, RegDst, MemtoReg;
   logic       ALUSrcA, ExtOp, rtype, instr_done, trap;
   logic [1:0] PCSrc, ALUSrcB, trap_cause;
   logic [2:0] ALUctr;
   logic [3:0] retired;
   logic [17:0] ctl;

   int checks = 0;
   int errors = 0;

   always #5 sys_clk = ~sys_clk;

   multicycle_ctrl #(.ALUCTR_W(3), .CNT_W(4), .MEM_TIMEOUT(4)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .op(op), .func(func),
      .zero(zero), .mem_ready(mem_ready), .PCWr(PCWr), .PCSrc(PCSrc),
      .IRWr(IRWr), .MemRd(MemRd), .MemWr(MemWr), .IorD(IorD),
      .RegWr(RegWr), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .ALUctr(ALUctr),
      .rtype(rtype), .instr_done(instr_done), .retired(retired),
      .trap(trap), .trap_cause(trap_cause)
   );

   assign ctl = {PCWr, PCSrc, IRWr, MemRd, MemWr, IorD, RegWr, RegDst,
                 MemtoReg, ALUSrcA, ALUSrcB, ExtOp, ALUctr, instr_done};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   initial begin
      sys_rst = 1'b1; op = 6'b0; func = 6'b0; zero = 1'b0; mem_ready = 1'b1;
      #1;
      chk("rst_ctl", ctl, 0);
      chk("rst_retired", retired, 0);
      chk("rst_trap", trap, 0);
      chk("rst_cause", trap_cause, 0);
      tick(); tick();
      chk("rst_ctl_held", ctl, 0);
      sys_rst = 1'b0;
      #1;

      // ---- add: FETCH, DECODE, EXEC, WB ----
      func = 6'b100000;
      chk("add_f_memrd", MemRd, 1);
      chk("add_f_irwr", IRWr, 1);
      chk("add_f_pcwr", PCWr, 1);
      chk("add_f_pcsrc", PCSrc, 0);
      chk("add_f_iord", IorD, 0);
      chk("add_f_srcb", ALUSrcB, 1);
      chk("add_f_alu", ALUctr, 3'b010);
      tick();
      chk("add_d_srcb", ALUSrcB, 3);
      chk("add_d_ext", ExtOp, 1);
      chk("add_d_pcwr", PCWr, 0);
      chk("add_d_rtype", rtype, 1);
      tick();
      chk("add_e_srca", ALUSrcA, 1);
      chk("add_e_srcb", ALUSrcB, 0);
      chk("add_e_alu", ALUctr, 3'b010);
      chk("add_e_done", instr_done, 0);
      tick();
      chk("add_w_regwr", RegWr, 1);
      chk("add_w_regdst", RegDst, 1);
      chk("add_w_memtoreg", MemtoReg, 0);
      chk("add_w_done", instr_done, 1);
      chk("add_w_retired", retired, 0);
      tick();
      chk("add_retired", retired, 1);
      chk("add_back_fetch", MemRd, 1);

      // ---- lw with 3 wait cycles, ready on the limit cycle ----
      op = 6'b100011;
      tick();                     // DECODE
      tick();                     // EXEC
      chk("lw_e_srcb", ALUSrcB, 2);
      chk("lw_e_ext", ExtOp, 1);
      chk("lw_e_alu", ALUctr, 3'b010);
      chk("lw_e_rtype", rtype, 0);
      mem_ready = 1'b0;
      tick();                     // MEM wait 1
      chk("lw_m1_rd_iord", {MemRd, IorD, MemWr}, 3'b110);
      tick();                     // MEM wait 2
      tick();                     // MEM wait 3
      chk("lw_m3_rd_iord", {MemRd, IorD}, 2'b11);
      chk("lw_m3_done", instr_done, 0);
      tick();                     // MEM cycle 4 = limit cycle
      mem_ready = 1'b1;
      #1;
      chk("lw_m4_rd_iord", {MemRd, IorD}, 2'b11);
      chk("lw_m4_trap", trap, 0);
      tick();                     // WB
      chk("lw_w_memtoreg", MemtoReg, 1);
      chk("lw_w_regdst", RegDst, 0);
      chk("lw_w_regwr", RegWr, 1);
      chk("lw_w_done", instr_done, 1);
      tick();
      chk("lw_retired", retired, 2);
      chk("lw_trap", trap, 0);

      // ---- beq taken, then not taken ----
      op = 6'b000100; zero = 1'b1;
      tick(); tick();             // EXEC
      chk("beq1_pcwr", PCWr, 1);
      chk("beq1_pcsrc", PCSrc, 1);
      chk("beq1_alu", ALUctr, 3'b110);
      chk("beq1_srcab", {ALUSrcA, ALUSrcB}, 3'b100);
      chk("beq1_done", instr_done, 1);
      tick();
      chk("beq1_retired", retired, 3);
      chk("beq1_fetch", MemRd, 1);
      zero = 1'b0;
      tick(); tick();
      chk("beq0_pcwr", PCWr, 0);
      chk("beq0_done", instr_done, 1);
      tick();
      chk("beq0_retired", retired, 4);

      // ---- j ----
      op = 6'b000010;
      tick();                     // DECODE
      chk("j_pcwr", PCWr, 1);
      chk("j_pcsrc", PCSrc, 2);
      chk("j_done", instr_done, 1);
      tick();                     // FETCH on cycle 3
      chk("j_fetch", {MemRd, IRWr}, 2'b11);
      chk("j_retired", retired, 5);

      // ---- FETCH stall, then ori ----
      op = 6'b001101;
      mem_ready = 1'b0;
      #1;
      chk("stall_ctl", {MemRd, IRWr, PCWr}, 3'b100);
      tick();
      chk("stall_hold", {MemRd, IRWr}, 2'b10);
      mem_ready = 1'b1;
      tick(); tick();             // EXEC
      chk("ori_e_srcb", ALUSrcB, 2);
      chk("ori_e_ext", ExtOp, 0);
      chk("ori_e_alu", ALUctr, 3'b001);
      tick();
      chk("ori_w_regdst", RegDst, 0);
      tick();
      chk("ori_retired", retired, 6);

      // ---- counter wrap: ten jumps take 6 -> 16 = 0 mod 16 ----
      op = 6'b000010;
      for (int i = 0; i < 10; i++) begin
         tick(); tick();
      end
      chk("wrap_retired", retired, 0);

      // ---- illegal opcode ----
      op = 6'b111111;
      tick();                     // DECODE
      chk("ill_d_done", instr_done, 0);
      tick();
      chk("ill_trap", trap, 1);
      chk("ill_cause", trap_cause, 1);
      chk("ill_ctl", ctl, 0);
      tick();
      chk("ill_sticky", {trap, trap_cause}, 3'b101);
      sys_rst = 1'b1;
      #1;
      chk("ill_rst_trap", trap, 0);
      chk("ill_rst_ctl", ctl, 0);
      tick();
      sys_rst = 1'b0;
      #1;
      chk("ill_rst_fetch", MemRd, 1);
      chk("ill_rst_cause", trap_cause, 0);

      // ---- R-type with unknown func ----
      op = 6'b000000; func = 6'b111111;
      tick(); tick();
      chk("badfn_trap", {trap, trap_cause}, 3'b101);
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      #1;

      // ---- j then sw with memory never ready -> timeout ----
      op = 6'b000010;
      tick(); tick();
      chk("to_j_retired", retired, 1);
      op = 6'b101011;
      tick(); tick();             // EXEC
      chk("sw_e_srcb", ALUSrcB, 2);
      mem_ready = 1'b0;
      tick();                     // MEM wait 1
      chk("sw_m1_ctl", {MemWr, IorD, MemRd}, 3'b110);
      tick(); tick(); tick();     // MEM wait 4
      chk("sw_m4_memwr", MemWr, 1);
      chk("sw_m4_trap", trap, 0);
      tick();
      chk("sw_to_trap", trap, 1);
      chk("sw_to_cause", trap_cause, 2);
      chk("sw_to_memwr", MemWr, 0);
      chk("sw_to_retired", retired, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle MIPS control unit. It is the sequential successor to the single-cycle cpuCtr decoder and covers the same instruction set: add, sub, and, or, slt, ori, addiu, lw, sw, beq, j. A state machine sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. It waits on a memory-ready handshake, has an optional memory timeout, flags illegal opcodes, and counts retired instructions. It drives the shared-ALU multi-cycle datapath.

Parameters:
ALUCTR_W, 3, width of ALUctr; encodings are zero-extended into it.
CNT_W, 32, width of the retired-instruction counter.
MEM_TIMEOUT, 0, maximum wait cycles on mem_ready; 0 disables the timeout.

Ports:
sys_clk  in  1  clock
sys_rst  in  1  synchronous, active-high reset
op  in  6  instruction[31:26] from the IR
func  in  6  instruction[5:0] from the IR
zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
PCWr  out  1  PC write enable
PCSrc  out  2  PC source: 00 ALU result, 01 ALUOut (branch target), 10 jump target
IRWr  out  1  IR write enable
MemRd  out  1  memory read request
MemWr  out  1  memory write request
IorD  out  1  memory address select: 0 PC, 1 ALUOut
RegWr  out  1  register file write enable
RegDst  out  1  destination: 1 rd, 0 rt
MemtoReg  out  1  write-back source: 1 MDR, 0 ALUOut
ALUSrcA  out  1  ALU A: 0 PC, 1 rs
ALUSrcB  out  2  ALU B: 00 rt, 01 constant 4, 10 ext(imm), 11 ext(imm)<<2
ExtOp  out  1  1 sign-extend, 0 zero-extend
ALUctr  out  ALUCTR_W  ALU operation: and=000, or=001, add=010, sub=110, slt=111
rtype  out  1  latched opcode is R-type
instr_done  out  1  one-cycle pulse when an instruction retires
retired  out  CNT_W  count of retired instructions
trap  out  1  sticky fault flag
trap_cause  out  2  00 none, 01 illegal op/func, 10 memory timeout

Behaviour:
- State encoding: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset:
  - While sys_rst=1, every output is 0: retired=0, trap=0, trap_cause=00.
  - State becomes FETCH and the internal op_q/func_q/wait counter are cleared.
  - Reset asserted mid-instruction aborts it; no retire is counted.
- Output timing: outputs are combinational from state, op_q, func_q, zero and mem_ready. State and op_q are registered.
- FETCH:
  - Drives MemRd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUctr=add.
  - When mem_ready=1, additionally drives IRWr=1, PCWr=1, PCSrc=00, and the next state is DECODE. Otherwise the FSM holds in FETCH.
- DECODE:
  - Latches op/func into op_q/func_q.
  - Drives ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUctr=add (branch target into ALUOut).
  - j: PCWr=1, PCSrc=10, instr_done=1, next state FETCH.
  - Illegal op, or R-type with an unknown func: next state TRAP with cause 01.
  - Otherwise the next state is EXEC.
- EXEC:
  - R-type: ALUSrcA=1, ALUSrcB=00, ALUctr from func; next state WB.
  - ori: ALUSrcA=1, ALUSrcB=10, ExtOp=0, ALUctr=or; next state WB.
  - addiu: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUctr=add; next state WB.
  - lw/sw: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUctr=add; next state MEM.
  - beq: ALUSrcA=1, ALUSrcB=00, ALUctr=sub, PCWr=zero, PCSrc=01, instr_done=1; next state FETCH.
- MEM:
  - Drives IorD=1.
  - lw: MemRd=1. On mem_ready, next state WB.
  - sw: MemWr=1. On mem_ready, instr_done=1 and next state FETCH.
- WB:
  - Drives RegWr=1, instr_done=1; next state FETCH.
  - RegDst=1 for R-type. MemtoReg=1 for lw.
- Memory timeout:
  - The wait counter clears on entry to FETCH/MEM and increments each cycle with mem_ready=0.
  - With MEM_TIMEOUT>0, reaching MEM_TIMEOUT wait cycles moves the FSM to TRAP with cause 10.
  - A mem_ready arriving on the same cycle as the limit wins; the access completes normally.
- TRAP:
  - All control outputs are 0; trap=1 with the cause held.
  - Exits only on sys_rst.
- Counter: retired increments on the instr_done pulse and wraps modulo 2^CNT_W without saturating.
- Latency with zero-wait memory: j 2 cycles; beq 3; R-type, ori, addiu and sw 4; lw 5. Each cycle of mem_ready=0 adds 1.

Decomposition:
- mips_ctrl_pkg holds the opcode and func constants, the ALUctr encodings, the state enum, the PCSrc/ALUSrcB encodings and the trap-cause codes.
- One sub-module, alu_decode: purely combinational, maps (op_q, func_q) to ALUctr, rtype and a legal flag. It is shared with cpuCtr.

Test Plan:
1. add (op=000000, func=100000), mem_ready tied 1 -> states FETCH, DECODE, EXEC, WB. In EXEC, ALUctr=010. In WB, RegWr=1 and RegDst=1. retired goes 0->1 on the 4th cycle.
2. lw (op=100011), mem_ready low for 3 cycles in MEM -> MemRd=1 and IorD=1 held for 4 cycles. In WB, MemtoReg=1 and RegDst=0. Total 8 cycles.
3. beq (op=000100) with zero=1, then zero=0 -> EXEC asserts PCWr=1 with PCSrc=01 in the first case, PCWr=0 in the second. Both take 3 cycles and both pulse instr_done.
4. j (op=000010) -> DECODE asserts PCWr=1 with PCSrc=10. Back in FETCH on cycle 3. retired increments.
5. op=111111 -> trap=1, trap_cause=01 after DECODE, all controls 0. sys_rst pulse -> FETCH, trap=0.
6. MEM_TIMEOUT=4, sw with mem_ready never asserted -> TRAP with cause 10 after 4 MEM wait cycles. MemWr deasserts and retired is unchanged.
